// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: parser state encoding, header constants and
// a helper that picks one address byte in wire order.
package eth_pkg;

  localparam int unsigned MAC_W       = 48;
  localparam int unsigned ETH_HDR_LEN = 14;
  localparam logic [MAC_W-1:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDst,
    StSrc,
    StType,
    StPayload,
    StDrain
  } rx_state_e;

  // Byte idx of a MAC address in transmission order (idx 0 = most significant).
  function automatic logic [7:0] mac_byte(input logic [MAC_W-1:0] mac, input logic [2:0] idx);
    return mac[(MAC_W - 8) - 8 * int'(idx) +: 8];
  endfunction

endpackage

// File: rtl/eth_rx_parser.sv
// Parses length-delimited frames from a show-ahead RX FIFO, filters on the
// destination address and streams the payload out with a one-deep output register.
module eth_rx_parser
  import eth_pkg::*;
#(
  parameter logic [MAC_W-1:0] BOARD_MAC = 48'h7E3C32E74851,
  parameter int unsigned      MAX_LEN   = 1518
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_ready,
  output logic        o_rx_req,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_ethertype,
  output logic        o_bcast,
  output logic [15:0] o_drop_cnt
);

  localparam logic [15:0] MaxLen = 16'(MAX_LEN);
  localparam logic [15:0] MinLen = 16'(ETH_HDR_LEN + 1);

  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        mac_hit_q, mac_hit_d;
  logic        bc_hit_q, bc_hit_d;
  logic [7:0]  type_hi_q, type_hi_d;
  logic        first_q, first_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [15:0] ethertype_q, ethertype_d;
  logic        bcast_q, bcast_d;
  logic [15:0] drop_q, drop_d;

  logic        rx_req;
  logic        drop_inc;
  logic        m_hit, b_hit;
  logic [15:0] len_w;

  assign len_w = {cnt_q[15:8], i_rx_data};

  always_comb begin
    rx_req = i_rx_ready;
    unique case (state_q)
      StIdle:    rx_req = 1'b0;
      StPayload: rx_req = i_rx_ready & (~valid_q | i_ready);
      default:   rx_req = i_rx_ready;
    endcase
    rx_req = rx_req & ~i_rst;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mac_hit_d   = mac_hit_q;
    bc_hit_d    = bc_hit_q;
    type_hi_d   = type_hi_q;
    first_d     = first_q;
    data_d      = data_q;
    valid_d     = valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    ethertype_d = ethertype_q;
    bcast_d     = bcast_q;
    drop_inc    = 1'b0;
    m_hit       = mac_hit_q & (i_rx_data == mac_byte(BOARD_MAC, idx_q));
    b_hit       = bc_hit_q & (i_rx_data == mac_byte(ETH_BCAST, idx_q));

    if (valid_q && i_ready) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_rx_ready) state_d = StLenHi;
      end
      StLenHi: begin
        if (rx_req) begin
          cnt_d   = {i_rx_data, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (rx_req) begin
          cnt_d = len_w;
          if (len_w < MinLen || len_w > MaxLen) begin
            drop_inc = 1'b1;
            state_d  = (len_w == 16'd0) ? StIdle : StDrain;
          end else begin
            idx_d     = 3'd0;
            mac_hit_d = 1'b1;
            bc_hit_d  = 1'b1;
            state_d   = StDst;
          end
        end
      end
      StDst: begin
        if (rx_req) begin
          cnt_d     = cnt_q - 16'd1;
          mac_hit_d = m_hit;
          bc_hit_d  = b_hit;
          if (idx_q == 3'd5) begin
            idx_d = 3'd0;
            if (!m_hit && !b_hit) begin
              drop_inc = 1'b1;
              state_d  = StDrain;
            end else begin
              state_d = StSrc;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StSrc: begin
        if (rx_req) begin
          cnt_d = cnt_q - 16'd1;
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = StType;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StType: begin
        if (rx_req) begin
          cnt_d = cnt_q - 16'd1;
          if (idx_q == 3'd0) begin
            type_hi_d = i_rx_data;
            idx_d     = 3'd1;
          end else begin
            idx_d       = 3'd0;
            ethertype_d = {type_hi_q, i_rx_data};
            bcast_d     = bc_hit_q;
            first_d     = 1'b1;
            state_d     = StPayload;
          end
        end
      end
      StPayload: begin
        if (cnt_q == 16'd0) begin
          // Last byte is waiting in the output register; once it leaves, the
          // next frame's length byte may be popped in the same cycle.
          if (!valid_q || i_ready) begin
            if (rx_req) begin
              cnt_d   = {i_rx_data, 8'h00};
              state_d = StLenLo;
            end else begin
              state_d = StIdle;
            end
          end
        end else if (rx_req) begin
          data_d  = i_rx_data;
          valid_d = 1'b1;
          sof_d   = first_q;
          eof_d   = (cnt_q == 16'd1);
          first_d = 1'b0;
          cnt_d   = cnt_q - 16'd1;
        end
      end
      StDrain: begin
        if (cnt_q == 16'd0) begin
          state_d = StIdle;
        end else if (rx_req) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    drop_d = drop_q;
    if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      mac_hit_q   <= 1'b0;
      bc_hit_q    <= 1'b0;
      type_hi_q   <= 8'd0;
      first_q     <= 1'b0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      ethertype_q <= 16'd0;
      bcast_q     <= 1'b0;
      drop_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mac_hit_q   <= mac_hit_d;
      bc_hit_q    <= bc_hit_d;
      type_hi_q   <= type_hi_d;
      first_q     <= first_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      ethertype_q <= ethertype_d;
      bcast_q     <= bcast_d;
      drop_q      <= drop_d;
    end
  end

  assign o_rx_req    = rx_req;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_ethertype = ethertype_q;
  assign o_bcast     = bcast_q;
  assign o_drop_cnt  = drop_q;

endmodule
